parallel_frame_tx: RTL and testbench
====================================

// Module: parallel_frame_tx
// PURPOSE
//  Parametrised multi-channel parallel frame transmitter. On START, streams FRAME_LEN words per
//  enabled channel from the memory-side stream onto the hardware parallel bus with a divided data clock.
//  Sits between frame memory and the external parallel port. Adds per-channel framing, programmable
//  bus rate, stall-on-underrun and a DONE pulse.
// PARAMETERS
//  DATA_W  8   data bus width (bits)
//  LEN_W   16  FRAME_LEN width; max 2^LEN_W-1 words per channel
//  NUM_CH  4   channel count; CH_W = max(1,$clog2(NUM_CH))
//  DIV_W   4   CLK_DIV width
//  GAP     2   idle CLK cycles between channel frames (FLAG_FRAME low)
// PORTS
//  CLK           in   1          system clock
//  RESET         in   1          asynchronous, active-high reset
//  START         in   1          1-cycle start request; ignored while BUSY
//  FRAME_LEN     in   LEN_W      words per channel, latched on START
//  CLK_DIV       in   DIV_W      DATA_OUT_CLK half-period = CLK_DIV+1 CLK cycles, latched on START
//  CH_MASK       in   NUM_CH     enabled channels, latched on START
//  IN_DATA       in   DATA_W     memory word
//  IN_VALID      in   1          IN_DATA valid
//  IN_READY      out  1          holding register empty; transfer on IN_VALID&&IN_READY
//  IN_CH         out  CH_W       channel being fetched (memory address select)
//  DATA_OUT      out  DATA_W     parallel bus data
//  DATA_OUT_CLK  out  1          parallel bus clock; receiver samples on rising edge
//  FLAG_FRAME    out  1          high while a channel frame is on the bus
//  CH_ID         out  CH_W       channel of current frame
//  BUSY          out  1          transfer in progress
//  FRAME_DONE    out  1          1-cycle pulse after last word of last enabled channel
//  UNDERRUN      out  1          sticky; cleared by next accepted START
// BEHAVIOUR
//  - Reset: all outputs 0, FSM IDLE, holding register empty (IN_READY=0 in IDLE).
//  - FSM: IDLE -> SEL -> LOW -> HIGH -> {LOW | GAP | DONE}; GAP -> SEL; DONE -> IDLE.
//  - IDLE: START latches FRAME_LEN/CLK_DIV/CH_MASK, clears UNDERRUN, BUSY=1, next state SEL.
//  - SEL: pick lowest enabled, not-yet-sent channel >= current; drive IN_CH; load word counter=FRAME_LEN.
//    No channel left, or FRAME_LEN==0 -> DONE. Latency START->FRAME_DONE with nothing to send = 2 cycles.
//  - IN_READY=1 in SEL/LOW/HIGH while holding register empty and words remain to fetch for the channel.
//  - LOW: DATA_OUT_CLK=0, FLAG_FRAME=1, DATA_OUT=current word. Entry loads current word from holding reg.
//    If holding reg empty at entry: stall in LOW, DATA_OUT_CLK stays 0, UNDERRUN<=1; resume on arrival.
//    Stay CLK_DIV+1 cycles, then HIGH.
//  - HIGH: DATA_OUT_CLK=1, DATA_OUT stable; CLK_DIV+1 cycles. Counter dec at exit. Remaining>0 -> LOW;
//    else GAP (more channels) or DONE. Word period = 2*(CLK_DIV+1) CLK; no bubble when fed.
//  - GAP: FLAG_FRAME=0, DATA_OUT_CLK=0 for GAP cycles (0 = skip). CH_ID updates in SEL.
//  - DONE: FRAME_DONE=1 for one cycle, BUSY=0 next cycle; DATA_OUT holds last word.
//  - START while BUSY: ignored, no state change. FRAME_LEN/CLK_DIV changes mid-transfer: no effect.
//  - Counter: LEN_W bits, never wraps (stops at 0). CLK_DIV=0 -> DATA_OUT_CLK = CLK/2.
//  - RESET mid-transfer: immediate return to reset values; in-flight word discarded.
// CONFIGURATION
//  FRAME_HEADER_EN defined: each channel frame is preceded by one header word on the bus,
//    {channel index zero-extended to DATA_W} with full LOW/HIGH timing, FLAG_FRAME=1; not fetched from
//    memory, not counted in FRAME_LEN. FRAME_LEN==0 channels still skipped (no header).
//  FRAME_HEADER_EN undefined: no header; frame = FRAME_LEN data words only.
// TESTING
//  1 CH_MASK=4'b0001, FRAME_LEN=4, CLK_DIV=0, IN_VALID=1 data 0x10..0x13 -> 4 rising edges, 2-CLK
//    period, bus 0x10,0x11,0x12,0x13; FRAME_DONE pulse once; UNDERRUN=0.
//  2 CH_MASK=4'b1010, FRAME_LEN=2, CLK_DIV=1, GAP=2 -> CH_ID 1 then 3, IN_CH matches,
//    FLAG_FRAME low exactly 2 cycles between frames, edge period 4 CLK.
//  3 IN_VALID low 10 cycles before word 2 -> DATA_OUT_CLK held low, UNDERRUN=1, word 2 sent after
//    arrival; next START clears UNDERRUN.
//  4 FRAME_LEN=0 or CH_MASK=0 -> no edges, FLAG_FRAME stays 0, FRAME_DONE 2 cycles after START.
//  5 RESET asserted mid-word, START pulsed while BUSY -> outputs 0 asynchronously; second START ignored
//    (word count unchanged).
//  6 FRAME_HEADER_EN, CH_MASK=4'b0100, FRAME_LEN=3 -> bus 0x02, d0, d1, d2; only 3 memory reads.

Source files
------------

// File: rtl/parallel_frame_tx_if.sv
// Memory-side word stream for parallel_frame_tx: data/valid toward the
// transmitter, ready and channel select back toward frame memory.
interface parallel_frame_tx_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  logic [DATA_W-1:0] IN_DATA;
  logic              IN_VALID;
  logic              IN_READY;
  logic [CH_W-1:0]   IN_CH;

  modport master (output IN_DATA, IN_VALID, input IN_READY, IN_CH);
  modport slave  (input IN_DATA, IN_VALID, output IN_READY, IN_CH);
endinterface

// File: rtl/parallel_frame_tx.sv
// Multi-channel parallel frame transmitter with divided bus clock, inter-frame gap,
// stall-on-underrun. Optional FRAME_HEADER_EN prepends a channel-index word per frame.
module parallel_frame_tx #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16,
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 4,
  parameter int GAP    = 2,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  START,
  input  logic [LEN_W-1:0]      FRAME_LEN,
  input  logic [DIV_W-1:0]      CLK_DIV,
  input  logic [NUM_CH-1:0]     CH_MASK,
  parallel_frame_tx_if.slave    mem,
  output logic [DATA_W-1:0]     DATA_OUT,
  output logic                  DATA_OUT_CLK,
  output logic                  FLAG_FRAME,
  output logic [CH_W-1:0]       CH_ID,
  output logic                  BUSY,
  output logic                  FRAME_DONE,
  output logic                  UNDERRUN
);

`ifdef FRAME_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  // GAP state covers GAP-1 cycles; SEL supplies the last low-flag cycle.
  localparam int GAP_W    = (GAP > 2) ? $clog2(GAP - 1) : 1;
  localparam int GAP_LAST = (GAP >= 2) ? GAP - 2 : 0;

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOW, S_HIGH, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [NUM_CH-1:0]  pend_q, pend_d, pend_nx;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dclk_q, dclk_d;
  logic               flag_q, flag_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               unr_q, unr_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [LEN_W-1:0]   word_rem_q, word_rem_d;
  logic [LEN_W-1:0]   fetch_rem_q, fetch_rem_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               loaded_q, loaded_d;
  logic               hdr_q, hdr_d;

  logic [CH_W-1:0]    pick;
  logic               found, sel_ok, in_ready, in_fire, avail, enter_low;
  logic [DATA_W-1:0]  avail_data;

  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++)
      if (pend_q[i] && !found) begin
        pick  = CH_W'(i);
        found = 1'b1;
      end
  end

  assign sel_ok   = found && (len_q != '0);
  assign in_ready = !hold_full_q &&
                    ((state_q == S_SEL && sel_ok) ||
                     ((state_q == S_LOW || state_q == S_HIGH) && fetch_rem_q != '0));
  assign in_fire  = mem.IN_VALID && in_ready;
  // A word accepted this cycle can go straight to the bus, bypassing the holding reg.
  assign avail      = hold_full_q || in_fire;
  assign avail_data = hold_full_q ? hold_q : mem.IN_DATA;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    div_d       = div_q;
    pend_d      = pend_q;
    ch_d        = ch_q;
    data_d      = data_q;
    dclk_d      = dclk_q;
    flag_d      = flag_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    unr_d       = unr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    word_rem_d  = word_rem_q;
    fetch_rem_d = fetch_rem_q;
    div_cnt_d   = div_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    loaded_d    = loaded_q;
    hdr_d       = hdr_q;
    enter_low   = 1'b0;
    pend_nx     = pend_q;
    pend_nx[ch_q] = 1'b0;

    if (in_fire) begin
      hold_d      = mem.IN_DATA;
      hold_full_d = 1'b1;
      if (state_q != S_SEL && fetch_rem_q != '0) fetch_rem_d = fetch_rem_q - LEN_W'(1);
    end

    case (state_q)
      S_IDLE: if (START) begin
        len_d   = FRAME_LEN;
        div_d   = CLK_DIV;
        pend_d  = CH_MASK;
        unr_d   = 1'b0;
        busy_d  = 1'b1;
        state_d = S_SEL;
      end
      S_SEL: begin
        if (!sel_ok) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          flag_d  = 1'b0;
        end else begin
          ch_d        = pick;
          word_rem_d  = len_q;
          fetch_rem_d = len_q - LEN_W'(in_fire);
          flag_d      = 1'b1;
          if (HDR_EN) begin
            state_d   = S_LOW;
            dclk_d    = 1'b0;
            div_cnt_d = '0;
            data_d    = DATA_W'(pick);
            loaded_d  = 1'b1;
            hdr_d     = 1'b1;
          end else begin
            enter_low = 1'b1;
          end
        end
      end
      S_LOW: begin
        if (!loaded_q) begin
          if (avail) begin
            data_d      = avail_data;
            hold_full_d = 1'b0;
            loaded_d    = 1'b1;
            div_cnt_d   = '0;
          end
        end else if (div_cnt_q == div_q) begin
          state_d   = S_HIGH;
          dclk_d    = 1'b1;
          div_cnt_d = '0;
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end
      S_HIGH: begin
        if (div_cnt_q != div_q) begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end else if (hdr_q) begin
          hdr_d     = 1'b0;
          enter_low = 1'b1;
        end else begin
          dclk_d     = 1'b0;
          div_cnt_d  = '0;
          word_rem_d = (word_rem_q != '0) ? word_rem_q - LEN_W'(1) : '0;
          if (word_rem_q > LEN_W'(1)) begin
            enter_low = 1'b1;
          end else begin
            pend_d = pend_nx;
            if (pend_nx == '0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              flag_d  = 1'b0;
            end else if (GAP == 0) begin
              state_d = S_SEL;
            end else if (GAP == 1) begin
              state_d = S_SEL;
              flag_d  = 1'b0;
            end else begin
              state_d   = S_GAP;
              gap_cnt_d = '0;
              flag_d    = 1'b0;
            end
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_LAST)) state_d = S_SEL;
        else gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Entering LOW with nothing to show is an underrun: clock stays low until data arrives.
    if (enter_low) begin
      state_d   = S_LOW;
      dclk_d    = 1'b0;
      div_cnt_d = '0;
      if (avail) begin
        data_d      = avail_data;
        hold_full_d = 1'b0;
        loaded_d    = 1'b1;
      end else begin
        loaded_d = 1'b0;
        unr_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      div_q       <= '0;
      pend_q      <= '0;
      ch_q        <= '0;
      data_q      <= '0;
      dclk_q      <= 1'b0;
      flag_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      unr_q       <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      word_rem_q  <= '0;
      fetch_rem_q <= '0;
      div_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      loaded_q    <= 1'b0;
      hdr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      ch_q        <= ch_d;
      data_q      <= data_d;
      dclk_q      <= dclk_d;
      flag_q      <= flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      unr_q       <= unr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      word_rem_q  <= word_rem_d;
      fetch_rem_q <= fetch_rem_d;
      div_cnt_q   <= div_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      loaded_q    <= loaded_d;
      hdr_q       <= hdr_d;
    end
  end

  assign mem.IN_READY = in_ready;
  assign mem.IN_CH    = (state_q == S_SEL) ? pick : ch_q;
  assign DATA_OUT     = data_q;
  assign DATA_OUT_CLK = dclk_q;
  assign FLAG_FRAME   = flag_q;
  assign CH_ID        = ch_q;
  assign BUSY         = busy_q;
  assign FRAME_DONE   = done_q;
  assign UNDERRUN     = unr_q;

endmodule

// File: tb/tb_parallel_frame_tx.sv
// Scoreboard bench for parallel_frame_tx: words queued at memory fetch, checked at bus rising edges.
module tb_parallel_frame_tx;
  localparam int DATA_W = 8, LEN_W = 16, NUM_CH = 4, DIV_W = 4, GAP = 2, CH_W = 2;
`ifdef FRAME_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct { logic [DATA_W-1:0] data; logic [CH_W-1:0] ch; bit first; int dly; } plan_t;
  typedef struct { logic [DATA_W-1:0] data; logic [CH_W-1:0] ch; } exp_t;

  logic              CLK = 1'b0, RESET = 1'b1, START = 1'b0;
  logic [LEN_W-1:0]  FRAME_LEN = '0;
  logic [DIV_W-1:0]  CLK_DIV = '0;
  logic [NUM_CH-1:0] CH_MASK = '0;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DATA_OUT_CLK, FLAG_FRAME, BUSY, FRAME_DONE, UNDERRUN;
  logic [CH_W-1:0]   CH_ID;

  parallel_frame_tx_if #(.DATA_W(DATA_W), .CH_W(CH_W)) mif();

  parallel_frame_tx #(.DATA_W(DATA_W), .LEN_W(LEN_W), .NUM_CH(NUM_CH), .DIV_W(DIV_W), .GAP(GAP)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FRAME_LEN(FRAME_LEN), .CLK_DIV(CLK_DIV),
    .CH_MASK(CH_MASK), .mem(mif), .DATA_OUT(DATA_OUT), .DATA_OUT_CLK(DATA_OUT_CLK),
    .FLAG_FRAME(FLAG_FRAME), .CH_ID(CH_ID), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN));

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  plan_t plan[$];
  exp_t  exp_q[$];
  int edges = 0, done_cnt = 0, done_cyc = 0, flag_hi = 0, max_iv = 0, reads = 0, s_cyc = 0;
  int exp_period = 2;
  bit chk_period = 1'b1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic add_frame(input logic [CH_W-1:0] ch, input int n, input logic [DATA_W-1:0] base,
                           input int dly_idx, input int dly);
    plan_t p;
    for (int i = 0; i < n; i++) begin
      p.data  = base + DATA_W'(i);
      p.ch    = ch;
      p.first = (i == 0);
      p.dly   = (i == dly_idx) ? dly : 0;
      plan.push_back(p);
    end
  endtask

  task automatic start_xfer(input int len, input int div, input logic [NUM_CH-1:0] mask);
    FRAME_LEN = LEN_W'(len);
    CLK_DIV   = DIV_W'(div);
    CH_MASK   = mask;
    START     = 1'b1;
    s_cyc     = cyc;
    tick();
    START     = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int n  = 0;
    while (done_cnt == d0 && n < budget) begin tick(); n++; end
    chk("done_seen", 32'(done_cnt != d0), 1);
  endtask

  task automatic wait_edges(input int k, input int budget);
    int target = edges + k;
    int n = 0;
    while (edges < target && n < budget) begin tick(); n++; end
    chk("edge_seen", 32'(edges >= target), 1);
  endtask

  // Memory model: offers planned words, honouring per-word delays.
  initial begin
    plan_t cur;
    exp_t  e;
    bit    have;
    int    dly_left;
    have = 1'b0; dly_left = 0;
    mif.IN_VALID = 1'b0; mif.IN_DATA = '0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        have = 1'b0;
        mif.IN_VALID = 1'b0;
      end else begin
        if (!have && plan.size() > 0) begin cur = plan.pop_front(); have = 1'b1; dly_left = cur.dly; end
        if (have && dly_left > 0) begin mif.IN_VALID = 1'b0; dly_left--; end
        else if (have) begin mif.IN_VALID = 1'b1; mif.IN_DATA = cur.data; end
        else mif.IN_VALID = 1'b0;
        #1;
        if (mif.IN_VALID && mif.IN_READY) begin
          chk("in_ch", 32'(mif.IN_CH), 32'(cur.ch));
          if (HDR != 0 && cur.first) begin e.data = DATA_W'(cur.ch); e.ch = cur.ch; exp_q.push_back(e); end
          e.data = cur.data; e.ch = cur.ch; exp_q.push_back(e);
          reads++;
          have = 1'b0;
        end
      end
    end
  end

  // Bus monitor: checks each rising DATA_OUT_CLK against the scoreboard.
  initial begin
    logic dclk_p, flag_p;
    int low_run, frames, fedges, last_edge;
    exp_t e;
    dclk_p = 1'b0; flag_p = 1'b0; low_run = 0; frames = 0; fedges = 0; last_edge = 0;
    forever begin
      @(negedge CLK);
      if (DATA_OUT_CLK && !dclk_p) begin
        edges++;
        chk("sb_has_word", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("bus_data", 32'(DATA_OUT), 32'(e.data));
          chk("ch_id", 32'(CH_ID), 32'(e.ch));
          chk("flag_at_edge", 32'(FLAG_FRAME), 1);
        end
        if (fedges > 0) begin
          if (cyc - last_edge > max_iv) max_iv = cyc - last_edge;
          if (chk_period) chk("edge_period", 32'(cyc - last_edge), 32'(exp_period));
        end
        fedges++;
        last_edge = cyc;
      end
      if (FLAG_FRAME) flag_hi++;
      if (FLAG_FRAME && !flag_p) begin
        if (frames > 0) chk("gap_len", 32'(low_run), 32'(GAP));
        frames++;
      end
      low_run = FLAG_FRAME ? 0 : low_run + 1;
      if (!FLAG_FRAME) fedges = 0;
      if (FRAME_DONE) begin done_cnt++; done_cyc = cyc; end
      if (!BUSY) begin frames = 0; max_iv = 0; end
      dclk_p = DATA_OUT_CLK;
      flag_p = FLAG_FRAME;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, d0, f0, r0;
    repeat (3) tick();
    chk("rst_data", 32'(DATA_OUT), 0);
    chk("rst_dclk", 32'(DATA_OUT_CLK), 0);
    chk("rst_flag", 32'(FLAG_FRAME), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(FRAME_DONE), 0);
    chk("rst_unr", 32'(UNDERRUN), 0);
    chk("rst_ready", 32'(mif.IN_READY), 0);
    RESET = 1'b0;
    repeat (2) tick();

    // single channel, full rate
    exp_period = 2; chk_period = 1'b1;
    e0 = edges; d0 = done_cnt;
    add_frame(0, 4, 8'h10, -1, 0);
    start_xfer(4, 0, 4'b0001);
    wait_done(200);
    chk("t1_edges", 32'(edges - e0), 32'(4 + HDR));
    chk("t1_done_cnt", 32'(done_cnt - d0), 1);
    chk("t1_unr", 32'(UNDERRUN), 0);
    chk("t1_sb_empty", 32'(exp_q.size()), 0);
    tick();
    chk("t1_busy_off", 32'(BUSY), 0);
    chk("t1_done_pulse", 32'(FRAME_DONE), 0);

    // two sparse channels, divided clock, gap between frames
    exp_period = 4;
    e0 = edges;
    add_frame(1, 2, 8'h20, -1, 0);
    add_frame(3, 2, 8'h30, -1, 0);
    start_xfer(2, 1, 4'b1010);
    wait_done(300);
    chk("t2_edges", 32'(edges - e0), 32'(4 + 2 * HDR));
    chk("t2_sb_empty", 32'(exp_q.size()), 0);
    tick();

    // underrun before word 2
    chk_period = 1'b0;
    e0 = edges;
    add_frame(0, 4, 8'h40, 2, 10);
    start_xfer(4, 0, 4'b0001);
    wait_done(300);
    chk("t3_unr", 32'(UNDERRUN), 1);
    chk("t3_stall_held", 32'(max_iv >= 10), 1);
    chk("t3_edges", 32'(edges - e0), 32'(4 + HDR));
    chk("t3_sb_empty", 32'(exp_q.size()), 0);
    tick();
    chk_period = 1'b1;

    // nothing to send: zero length, then empty mask
    e0 = edges; f0 = flag_hi;
    start_xfer(0, 0, 4'b1111);
    wait_done(20);
    chk("t4_lat_len0", 32'(done_cyc - s_cyc), 2);
    chk("t4_unr_cleared", 32'(UNDERRUN), 0);
    tick();
    start_xfer(5, 0, 4'b0000);
    wait_done(20);
    chk("t4_lat_mask0", 32'(done_cyc - s_cyc), 2);
    chk("t4_edges", 32'(edges - e0), 0);
    chk("t4_flag_hi", 32'(flag_hi - f0), 0);
    tick();

    // START while busy is ignored
    exp_period = 4;
    e0 = edges; d0 = done_cnt;
    add_frame(0, 4, 8'h50, -1, 0);
    start_xfer(4, 1, 4'b0001);
    wait_edges(1, 100);
    start_xfer(9, 0, 4'b1111);
    wait_done(300);
    chk("t5_edges", 32'(edges - e0), 32'(4 + HDR));
    chk("t5_done_cnt", 32'(done_cnt - d0), 1);
    tick();

    // asynchronous reset mid-word
    exp_period = 8;
    add_frame(0, 4, 8'h60, -1, 0);
    start_xfer(4, 3, 4'b0001);
    wait_edges(1, 100);
    @(posedge CLK);
    #2;
    RESET = 1'b1;
    #1;
    chk("t5_rst_data", 32'(DATA_OUT), 0);
    chk("t5_rst_dclk", 32'(DATA_OUT_CLK), 0);
    chk("t5_rst_flag", 32'(FLAG_FRAME), 0);
    chk("t5_rst_busy", 32'(BUSY), 0);
    chk("t5_rst_chid", 32'(CH_ID), 0);
    chk("t5_rst_ready", 32'(mif.IN_READY), 0);
    repeat (2) tick();
    plan.delete();
    exp_q.delete();
    RESET = 1'b0;
    repeat (2) tick();

    // single middle channel (header build adds channel index word)
    exp_period = 2;
    e0 = edges; r0 = reads;
    add_frame(2, 3, 8'h70, -1, 0);
    start_xfer(3, 0, 4'b0100);
    wait_done(200);
    chk("t6_reads", 32'(reads - r0), 3);
    chk("t6_edges", 32'(edges - e0), 32'(3 + HDR));
    chk("t6_sb_empty", 32'(exp_q.size()), 0);
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
